// File: rtl/ysyx_23060278_ifu_seq.sv
// Multi-cycle fetch/commit sequencer: req/gnt/rvalid instruction fetch, single-cycle commit window, halt on ebreak.
// Optional fetch watchdog enabled by defining YSYX_23060278_FETCH_TIMEOUT_EN.
module ysyx_23060278_ifu_seq #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        pc_wen,
    output logic        reg_wen_gate,
    input  logic        halt_req,
    output logic        halted,
    output logic [31:0] instret,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   inst_load;
    logic   timeout_hit;

    // Empty guard block: the counter must be able to represent the timeout limit.
    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_timeout_exceeds_counter
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        imem_req     = 1'b0;
        imem_addr    = 32'd0;
        inst_valid   = 1'b0;
        pc_wen       = 1'b0;
        reg_wen_gate = 1'b0;
        inst_load    = 1'b0;
        case (state_reg)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        inst_load  = 1'b1;
                        state_next = S_EXEC;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_RESP: begin
                // A response arriving on the timeout cycle still wins.
                if (imem_rvalid) begin
                    inst_load  = 1'b1;
                    state_next = S_EXEC;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (halt_req) begin
                    state_next = S_HALT;
                end else begin
                    pc_wen       = 1'b1;
                    reg_wen_gate = 1'b1;
                    state_next   = S_REQ;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst    <= 32'd0;
            instret <= 32'd0;
            halted  <= 1'b0;
        end else begin
            if (inst_load) begin
                inst <= imem_rdata;
            end
            if (pc_wen) begin
                instret <= instret + 32'd1;
            end
            if (state_next == S_HALT) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef YSYX_23060278_FETCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    // Count reaches the limit on the edge that closes the last permitted RESP cycle.
    assign timeout_hit = (wait_cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg <= '0;
            fetch_err    <= 1'b0;
        end else begin
            if (state_reg == S_REQ && imem_gnt && !imem_rvalid) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == S_RESP && !imem_rvalid) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (state_reg == S_RESP && !imem_rvalid && timeout_hit) begin
                fetch_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060278_ifu_seq.sv
// Self-checking bench for ysyx_23060278_ifu_seq: directed scenarios plus randomized fetch latencies
// checked against a transaction-level timing model (cycles per instruction derived from wait counts).
`timescale 1ns/1ps
module tb_ysyx_23060278_ifu_seq;

    localparam int          TO       = 4;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        pc_wen;
    logic        reg_wen_gate;
    logic        halt_req = 1'b0;
    logic        halted;
    logic [31:0] instret;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for pc_reg: advances only on the commit strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= PC_RESET;
        else if (pc_wen) pc <= pc + 32'd4;
    end

    ysyx_23060278_ifu_seq #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst(inst),
        .inst_valid(inst_valid),
        .pc_wen(pc_wen),
        .reg_wen_gate(reg_wen_gate),
        .halt_req(halt_req),
        .halted(halted),
        .instret(instret),
        .fetch_err(fetch_err)
    );

    // Advance one cycle, apply inputs for the new cycle, leave time for outputs to settle.
    task automatic step(input logic g, input logic v, input logic [31:0] d, input logic h);
        @(posedge clk);
        #1;
        imem_gnt = g; imem_rvalid = v; imem_rdata = d; halt_req = h;
        #1;
    endtask

    // Leaves the sequencer in its IDLE cycle right after reset release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({imem_req, inst_valid, pc_wen, reg_wen_gate, halted, fetch_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000",
                     {imem_req, inst_valid, pc_wen, reg_wen_gate, halted, fetch_err});
        end
        checks++;
        if ({inst, instret, imem_addr} !== 96'd0) begin
            failures++;
            $display("FAIL reset_regs: inst=%h instret=%h addr=%h want all 0", inst, instret, imem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, inst_valid, pc_wen} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: strobes=%b want 000", {imem_req, inst_valid, pc_wen});
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        step(1'b1, 1'b1, 32'h0050_0093, 1'b0);
        checks++;
        if ({imem_req, inst_valid, pc_wen, reg_wen_gate, imem_addr} !== {4'b1000, PC_RESET}) begin
            failures++;
            $display("FAIL first_req: got %b/%h want 1000/%h",
                     {imem_req, inst_valid, pc_wen, reg_wen_gate}, imem_addr, PC_RESET);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({imem_req, inst_valid, pc_wen, reg_wen_gate, inst, instret} !== {4'b0111, 32'h0050_0093, 32'd0}) begin
            failures++;
            $display("FAIL first_exec: strobes=%b inst=%h instret=%0d want 0111/00500093/0",
                     {imem_req, inst_valid, pc_wen, reg_wen_gate}, inst, instret);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({imem_req, pc_wen, reg_wen_gate, imem_addr, instret} !== {3'b100, PC_RESET + 32'd4, 32'd1}) begin
            failures++;
            $display("FAIL first_next: req/wen=%b addr=%h instret=%0d want 100/%h/1",
                     {imem_req, pc_wen, reg_wen_gate}, imem_addr, instret, PC_RESET + 32'd4);
        end
        $display("txn first_fetch inst=%h instret=%0d", inst, instret);
    endtask

    task automatic test_gnt_wait();
        int req_cycles;
        int exec_cycles;
        logic [31:0] d;
        d = $urandom | 32'h1;
        req_cycles = 0;
        exec_cycles = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 3)       step(1'b0, c == 1, $urandom, 1'b0);
            else if (c == 3) step(1'b1, 1'b0, $urandom, 1'b0);
            else if (c == 5) step(1'b0, 1'b1, d, 1'b0);
            else             step(1'b0, 1'b0, $urandom, 1'b0);
            if (imem_req && imem_addr === PC_RESET) req_cycles++;
            if (inst_valid) begin
                exec_cycles++;
                checks++;
                if ({c, inst} !== {32'd6, d}) begin
                    failures++;
                    $display("FAIL gnt_wait_exec: cycle=%0d inst=%h want cycle 6 inst=%h", c, inst, d);
                end
            end
        end
        checks++;
        if (req_cycles !== 4) begin
            failures++;
            $display("FAIL gnt_wait_req: req cycles=%0d want 4", req_cycles);
        end
        checks++;
        if (exec_cycles !== 1) begin
            failures++;
            $display("FAIL gnt_wait_once: exec cycles=%0d want 1", exec_cycles);
        end
        checks++;
        if (instret !== 32'd1) begin
            failures++;
            $display("FAIL gnt_wait_instret: instret=%0d want 1", instret);
        end
        $display("txn gnt_wait inst=%h instret=%0d", inst, instret);
    endtask

    task automatic test_back_to_back();
        int pulses;
        int adjacent;
        logic prev_valid;
        logic [31:0] d;
        pulses = 0;
        adjacent = 0;
        prev_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            for (int c = 0; c < 2; c++) begin
                if (c == 0) step(1'b1, 1'b1, d, 1'b0);
                else        step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
                if (pc_wen) pulses++;
                if (prev_valid && inst_valid) adjacent++;
                prev_valid = inst_valid;
            end
            checks++;
            if ({inst_valid, pc_wen, inst} !== {2'b11, d}) begin
                failures++;
                $display("FAIL b2b_exec i=%0d: valid/wen=%b inst=%h want 11/%h", i, {inst_valid, pc_wen}, inst, d);
            end
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({pulses, adjacent, instret, imem_addr} !== {32'd10, 32'd0, 32'd10, PC_RESET + 32'd40}) begin
            failures++;
            $display("FAIL b2b_total: pulses=%0d adjacent=%0d instret=%0d addr=%h want 10/0/10/%h",
                     pulses, adjacent, instret, imem_addr, PC_RESET + 32'd40);
        end
        $display("txn back_to_back instret=%0d", instret);
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_ret;
        logic [31:0] d;
        int g;
        int r;
        do_reset();
        exp_pc = PC_RESET;
        exp_inst = 32'd0;
        exp_ret = 32'd0;
        for (int k = 0; k < 20; k++) begin
            g = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            d = $urandom;
            for (int c = 0; c <= g; c++) begin
                if (c < g) step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
                else       step(1'b1, r == 0, (r == 0) ? d : $urandom, 1'($urandom_range(0, 1)));
                checks++;
                if ({imem_req, inst_valid, pc_wen, reg_wen_gate, imem_addr, inst} !== {4'b1000, exp_pc, exp_inst}) begin
                    failures++;
                    $display("FAIL rnd_req k=%0d c=%0d: strobes=%b addr=%h inst=%h want 1000/%h/%h",
                             k, c, {imem_req, inst_valid, pc_wen, reg_wen_gate}, imem_addr, inst, exp_pc, exp_inst);
                end
            end
            for (int c = 1; c <= r; c++) begin
                step(1'b0, c == r, (c == r) ? d : $urandom, 1'($urandom_range(0, 1)));
                checks++;
                if ({imem_req, inst_valid, pc_wen, reg_wen_gate, imem_addr, inst} !== {4'b0000, 32'd0, exp_inst}) begin
                    failures++;
                    $display("FAIL rnd_resp k=%0d c=%0d: strobes=%b addr=%h inst=%h want 0000/0/%h",
                             k, c, {imem_req, inst_valid, pc_wen, reg_wen_gate}, imem_addr, inst, exp_inst);
                end
            end
            exp_inst = d;
            step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
            checks++;
            if ({imem_req, inst_valid, pc_wen, reg_wen_gate, halted, inst, instret} !== {5'b01110, exp_inst, exp_ret}) begin
                failures++;
                $display("FAIL rnd_exec k=%0d: strobes=%b halted=%b inst=%h instret=%0d want 0111/0/%h/%0d",
                         k, {imem_req, inst_valid, pc_wen, reg_wen_gate}, halted, inst, instret, exp_inst, exp_ret);
            end
            exp_ret = exp_ret + 32'd1;
            exp_pc = exp_pc + 32'd4;
            $display("txn rnd k=%0d gnt_wait=%0d resp_wait=%0d inst=%h", k, g, r, d);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({imem_req, instret, imem_addr} !== {1'b1, exp_ret, exp_pc}) begin
            failures++;
            $display("FAIL rnd_final: req=%b instret=%0d addr=%h want 1/%0d/%h", imem_req, instret, imem_addr, exp_ret, exp_pc);
        end
    endtask

    task automatic test_halt();
        logic [31:0] d1;
        logic [31:0] d2;
        d1 = $urandom | 32'h1;
        d2 = $urandom | 32'h2;
        do_reset();
        step(1'b1, 1'b1, d1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, d2, 1'b0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, PC_RESET + 32'd4}) begin
            failures++;
            $display("FAIL halt_req_addr: req=%b addr=%h want 1/%h", imem_req, imem_addr, PC_RESET + 32'd4);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({imem_req, inst_valid, pc_wen, reg_wen_gate, halted, inst, instret} !== {5'b01000, d2, 32'd1}) begin
            failures++;
            $display("FAIL halt_exec: strobes=%b halted=%b inst=%h instret=%0d want 0100/0/%h/1",
                     {imem_req, inst_valid, pc_wen, reg_wen_gate}, halted, inst, instret, d2);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'($urandom_range(0, 1)));
            checks++;
            if ({imem_req, inst_valid, pc_wen, reg_wen_gate, halted, fetch_err, inst, instret} !== {6'b000010, d2, 32'd1}) begin
                failures++;
                $display("FAIL halt_hold i=%0d: strobes=%b halted=%b err=%b inst=%h instret=%0d want 0000/1/0/%h/1",
                         i, {imem_req, inst_valid, pc_wen, reg_wen_gate}, halted, fetch_err, inst, instret, d2);
            end
        end
        $display("txn halt halted=%b instret=%0d", halted, instret);
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] d1;
        logic [31:0] d2;
        d1 = $urandom | 32'h1;
        d2 = $urandom | 32'h4;
        do_reset();
        step(1'b1, 1'b1, d1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, $urandom, 1'b0);
        step(1'b0, 1'b0, $urandom, 1'b0);
        checks++;
        if ({imem_req, inst_valid, inst} !== {2'b00, d1}) begin
            failures++;
            $display("FAIL midrst_resp: req/valid=%b inst=%h want 00/%h", {imem_req, inst_valid}, inst, d1);
        end
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom;
        #1;
        checks++;
        if ({imem_req, inst_valid, inst, instret} !== {2'b00, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL midrst_async: req/valid=%b inst=%h instret=%0d want 00/0/0", {imem_req, inst_valid}, inst, instret);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = $urandom;
            #1;
        end
        @(posedge clk);
        #1;
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = $urandom;
        #1;
        checks++;
        if ({imem_req, inst_valid, inst} !== {2'b00, 32'd0}) begin
            failures++;
            $display("FAIL midrst_idle: req/valid=%b inst=%h want 00/0", {imem_req, inst_valid}, inst);
        end
        step(1'b1, 1'b1, d2, 1'b0);
        checks++;
        if ({imem_req, imem_addr, inst} !== {1'b1, PC_RESET, 32'd0}) begin
            failures++;
            $display("FAIL midrst_req: req=%b addr=%h inst=%h want 1/%h/0", imem_req, imem_addr, inst, PC_RESET);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({inst_valid, inst, instret} !== {1'b1, d2, 32'd0}) begin
            failures++;
            $display("FAIL midrst_exec: valid=%b inst=%h instret=%0d want 1/%h/0", inst_valid, inst, instret, d2);
        end
        $display("txn reset_mid_fetch inst=%h", inst);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        d = $urandom | 32'h8;
        do_reset();
        step(1'b1, 1'b0, $urandom, 1'b0);
`ifdef YSYX_23060278_FETCH_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            step(1'b0, 1'b0, $urandom, 1'b0);
            checks++;
            if ({imem_req, inst_valid, halted, fetch_err} !== 4'b0000) begin
                failures++;
                $display("FAIL to_wait i=%0d: req/valid/halted/err=%b want 0000", i,
                         {imem_req, inst_valid, halted, fetch_err});
            end
        end
        step(1'b0, 1'b1, d, 1'b0);
        checks++;
        if ({imem_req, inst_valid, pc_wen, halted, fetch_err, inst} !== {5'b00011, 32'd0}) begin
            failures++;
            $display("FAIL to_fire: req/valid/wen/halted/err=%b inst=%h want 00011/0",
                     {imem_req, inst_valid, pc_wen, halted, fetch_err}, inst);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({inst_valid, halted, fetch_err, inst, instret} !== {3'b011, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL to_hold: valid/halted/err=%b inst=%h instret=%0d want 011/0/0",
                     {inst_valid, halted, fetch_err}, inst, instret);
        end
        // rvalid on the limit cycle must still be accepted.
        do_reset();
        step(1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 1; i <= TO; i++) step(1'b0, i == TO, d, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({inst_valid, pc_wen, halted, fetch_err, inst} !== {4'b1100, d}) begin
            failures++;
            $display("FAIL to_race: valid/wen/halted/err=%b inst=%h want 1100/%h",
                     {inst_valid, pc_wen, halted, fetch_err}, inst, d);
        end
`else
        for (int i = 1; i <= 3 * TO; i++) begin
            step(1'b0, 1'b0, $urandom, 1'b0);
            checks++;
            if ({imem_req, inst_valid, halted, fetch_err} !== 4'b0000) begin
                failures++;
                $display("FAIL to_wait i=%0d: req/valid/halted/err=%b want 0000", i,
                         {imem_req, inst_valid, halted, fetch_err});
            end
        end
        step(1'b0, 1'b1, d, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({inst_valid, pc_wen, halted, fetch_err, inst} !== {4'b1100, d}) begin
            failures++;
            $display("FAIL to_late: valid/wen/halted/err=%b inst=%h want 1100/%h",
                     {inst_valid, pc_wen, halted, fetch_err}, inst, d);
        end
`endif
        $display("txn timeout fetch_err=%b halted=%b", fetch_err, halted);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_gnt_wait();
        test_back_to_back();
        test_random();
        test_halt();
        test_reset_mid_fetch();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060278_ifu_seq.md
Name: ysyx_23060278_ifu_seq

Overview:
Multi-cycle fetch/commit sequencer for the RV32 core.
- Issues a request/grant/response fetch of the instruction at the current pc to instruction memory and latches the returned word for the decoder.
- Opens a single commit cycle per instruction in which pc_reg and regfile are write-enabled.
- Replaces the constant pc_wen tie-off and gates the idu regwrite; stops the core on a halt request (ebreak).

Parameters:
TIMEOUT_CYCLES, 255, max cycles waited for imem_rvalid after grant (used only with optional feature)
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
pc  in  32  current pc from pc_reg
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; equals pc while imem_req=1, else 0
imem_gnt  in  1  request accepted
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetch data
inst  out  32  latched instruction to decoder
inst_valid  out  1  high for exactly the EXEC cycle
pc_wen  out  1  pc_reg write enable, one-cycle pulse
reg_wen_gate  out  1  ANDed with idu regwrite, one-cycle pulse
halt_req  in  1  from idu, sampled only in EXEC
halted  out  1  sticky halt indication
instret  out  32  retired-instruction counter
fetch_err  out  1  fetch timeout flag (optional feature)

Behaviour:
- Reset (rst=0, async, any state): state=IDLE, inst=0, instret=0, halted=0, fetch_err=0, timeout counter=0.
- Reset values of combinational outputs: imem_req=0, inst_valid=0, pc_wen=0, reg_wen_gate=0.
- FSM states: IDLE, REQ, RESP, EXEC, HALT.
- IDLE: all strobes 0; next=REQ unconditionally (first request one cycle after reset release).
- REQ: imem_req=1, imem_addr=pc.
  - gnt=1, rvalid=1: latch inst=imem_rdata, next=EXEC.
  - gnt=1, rvalid=0: next=RESP.
  - gnt=0: stay; request held stable.
- RESP: imem_req=0; wait for imem_rvalid; on rvalid latch inst, next=EXEC.
- EXEC: inst_valid=1; datapath is combinational and settles within this cycle.
  - halt_req=0: pc_wen=1, reg_wen_gate=1, instret+=1 at the edge, next=REQ.
  - halt_req=1: pc_wen=0, reg_wen_gate=0, instret unchanged, halted<=1, next=HALT.
  - The halting instruction is not retired.
- HALT: all strobes 0, halted=1; left only via reset.
- Throughput: 2 cycles/instr when gnt and rvalid arrive in the same REQ cycle; 3 cycles/instr with rvalid one cycle after gnt; +1 per extra wait cycle.
- inst holds its value outside EXEC; updated only on an accepted rvalid.
- imem_rvalid in IDLE/EXEC/HALT is ignored; in REQ it is honoured only together with gnt.
- instret is 32-bit and wraps 0xFFFFFFFF -> 0.
- pc must not change except on the pc_wen edge, so imem_addr is stable through REQ.
- Reset mid-fetch: in-flight response is dropped; sequencer restarts at IDLE, then REQ with the pc_reg reset value.

Optional Feature:
YSYX_23060278_FETCH_TIMEOUT_EN
- Defined:
  - Counter clears on entry to RESP and increments each RESP cycle without rvalid.
  - When the count reaches TIMEOUT_CYCLES: fetch_err<=1, halted<=1, next=HALT; no commit.
  - rvalid in the same cycle as the limit wins, and the instruction proceeds to EXEC.
- Not defined: RESP waits indefinitely; fetch_err tied to 0; no counter logic.

Test Plan:
- Release reset, gnt=1 and rvalid=1 with rdata=0x00500093 in the first REQ -> REQ at cycle 1, EXEC at cycle 2 with inst=0x00500093, pc_wen=reg_wen_gate=1 for 1 cycle, instret=1.
- gnt low 3 cycles, then gnt; rvalid 2 cycles later -> imem_req high 4 cycles with constant addr; EXEC exactly once; instret +1.
- Ten back-to-back instructions with zero-wait memory -> pc_wen pulses every 2 cycles; instret=10; inst_valid never high in consecutive cycles.
- halt_req=1 in EXEC -> pc_wen=0, reg_wen_gate=0, halted=1 permanently; instret unchanged; later rvalid ignored.
- rst asserted during RESP, then rvalid pulsed while in reset/IDLE -> inst stays 0; next REQ issues normally.
- With macro, TIMEOUT_CYCLES=4, no rvalid after gnt -> fetch_err=1 and halted=1 after 4 RESP cycles. Without macro, same stimulus -> stays in RESP and fetch_err=0.
